// File: rtl/pe_acc_if.sv
// ---------------------------------------------------------------------------
// pe_acc_if
// Handshake bundle between the PE multiplier stream and pe_accumulator.
//   start/len            : vector command (len sampled with start)
//   in_valid/in_ready    : product beat handshake, in_data signed product
//   out_valid/out_ready  : result handshake, out_data signed sum
//   busy                 : accumulator is working on or holding a vector
//   ovf                  : sticky saturation flag for the current vector
// master = producer/consumer side, slave = pe_accumulator.
// ---------------------------------------------------------------------------
interface pe_acc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN_WIDTH  = 10
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_data;
    logic                  busy;
    logic                  ovf;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, ovf
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, ovf
    );
endinterface

// File: rtl/pe_accumulator.sv
// ---------------------------------------------------------------------------
// pe_accumulator
// Sums a vector of signed PE products into a wide signed accumulator and
// returns one dot-product result per vector.
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : pe_acc_if.slave (start/len command, in_* product stream,
//          out_* result stream, busy, ovf)
// Optional feature: define PE_ACC_SAT_EN to make every add saturate to the
// signed ACC_WIDTH range and raise the sticky ovf flag on any clamp. Without
// it additions wrap modulo 2**ACC_WIDTH and ovf stays 0.
// ---------------------------------------------------------------------------
module pe_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN_WIDTH  = 10
) (
    input  logic     clk,
    input  logic     rst,
    pe_acc_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0]  in_sext;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  sum_clamped;

    assign in_sext = {{(ACC_WIDTH-DATA_WIDTH){bus.in_data[DATA_WIDTH-1]}}, bus.in_data};

`ifdef PE_ACC_SAT_EN
    // One guard bit: the add overflowed when the two top bits disagree, and
    // the guard bit then gives the true sign, i.e. which rail to clamp to.
    logic [ACC_WIDTH:0] sum_wide;

    always_comb begin
        sum_wide    = {acc_q[ACC_WIDTH-1], acc_q} + {in_sext[ACC_WIDTH-1], in_sext};
        sum_clamped = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
        sum         = sum_wide[ACC_WIDTH-1:0];
        if (sum_clamped) begin
            sum = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum         = acc_q + in_sext;
    assign sum_clamped = 1'b0;
`endif

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    count_d = '0;
                    len_d   = bus.len;
                    ovf_d   = 1'b0;
                    // An empty vector goes straight to HOLD with result 0.
                    state_d = (bus.len == '0) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                // in_ready is high for the whole state, so in_valid alone
                // marks an accepted beat.
                if (bus.in_valid) begin
                    acc_d   = sum;
                    ovf_d   = ovf_q | sum_clamped;
                    count_d = count_q + LEN_WIDTH'(1);
                    if (count_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others; the reset is asynchronous
    // and clears all state including the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs are the accumulator register or decodes of the state register.
    // acc_q is only cleared by start, so out_data keeps its value in IDLE.
    assign bus.in_ready  = (state_q == S_ACCUM);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_data  = acc_q;
    assign bus.ovf       = ovf_q;

endmodule
